// File: rtl/buzzer_pkg.sv
// Shared types and constants for the multi-channel buzzer tone generator.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } buzz_state_e;

  // Half-periods for common alarm pitches with a 100 MHz clock.
  localparam int DEF_HP_1KHZ = 50000;
  localparam int DEF_HP_2KHZ = 25000;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/buzzer_prio_sel.sv
// Highest-index-wins priority encoder used to pick the alarm channel to sound.
module buzzer_prio_sel #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  output logic              valid_o,
  output logic [CH_W-1:0]   idx_o
);

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Multi-channel alarm tone generator: per-channel pitch, shared beep cadence,
// optional beep-count limit and per-channel acknowledge.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int HP_W   = 20,
  parameter int CAD_W  = 24,
  parameter int BC_W   = 8,
  parameter int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      req,
  input  logic [NUM_CH*HP_W-1:0] half_per,
  input  logic [CAD_W-1:0]       cad_on,
  input  logic [CAD_W-1:0]       cad_off,
  input  logic [BC_W-1:0]        max_beeps,
  input  logic                   ack,
  output logic                   o_buzz,
  output logic                   active,
  output logic [CH_W-1:0]        active_ch,
  output logic                   done
);

  buzz_state_e       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [HP_W-1:0]   tone_q, tone_d;
  logic [CAD_W-1:0]  cad_q, cad_d;
  logic [BC_W-1:0]   beep_q, beep_d;
  logic              buzz_q, buzz_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] mask_q, mask_d;

  logic [NUM_CH-1:0] eligible;
  logic              win_valid;
  logic [CH_W-1:0]   win_ch;
  logic [HP_W-1:0]   win_hp;
  logic [HP_W-1:0]   cur_hp;
  logic [CAD_W-1:0]  eff_on_m1;
  logic              cad_on_last;
  logic              cad_off_last;
  logic              start;

  assign eligible = req & ~mask_q;

  buzzer_prio_sel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_prio (
    .req_i   (eligible),
    .valid_o (win_valid),
    .idx_o   (win_ch)
  );

  assign win_hp = half_per[int'(win_ch)*HP_W +: HP_W];
  assign cur_hp = half_per[int'(ch_q)*HP_W +: HP_W];

  // A zero on-time behaves like a one-cycle burst; a zero off-time ends the gap at once.
  assign eff_on_m1    = (cad_on == '0) ? '0 : cad_on - CAD_W'(1);
  assign cad_on_last  = (cad_q == eff_on_m1);
  assign cad_off_last = (cad_off == '0) || (cad_q == cad_off - CAD_W'(1));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    hp_d    = hp_q;
    tone_d  = tone_q;
    cad_d   = cad_q;
    beep_d  = beep_q;
    buzz_d  = buzz_q;
    done_d  = 1'b0;
    mask_d  = mask_q & req;
    start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        buzz_d = 1'b0;
        start  = win_valid;
      end
      ON, OFF: begin
        if (ack) begin
          mask_d[ch_q] = 1'b1;
          state_d      = IDLE;
          buzz_d       = 1'b0;
        end else if (!req[ch_q]) begin
          state_d = IDLE;
          buzz_d  = 1'b0;
        end else if (win_ch != ch_q) begin
          start = 1'b1;
        end else if (state_q == ON) begin
          if (hp_q == '0) begin
            buzz_d = 1'b0;
            tone_d = '0;
          end else if (tone_q == hp_q - HP_W'(1)) begin
            buzz_d = ~buzz_q;
            tone_d = '0;
          end else begin
            tone_d = tone_q + HP_W'(1);
          end
          if (cad_off != '0) begin
            if (cad_on_last) begin
              state_d = OFF;
              buzz_d  = 1'b0;
              tone_d  = '0;
              cad_d   = '0;
              if (beep_q != {BC_W{1'b1}}) beep_d = beep_q + BC_W'(1);
            end else begin
              cad_d = cad_q + CAD_W'(1);
            end
          end
        end else begin
          buzz_d = 1'b0;
          if (cad_off_last) begin
            if ((max_beeps != '0) && (beep_q == max_beeps)) begin
              mask_d[ch_q] = 1'b1;
              done_d       = 1'b1;
              state_d      = IDLE;
            end else begin
              state_d = ON;
              cad_d   = '0;
              tone_d  = '0;
              hp_d    = cur_hp;
            end
          end else begin
            cad_d = cad_q + CAD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Fresh service of a channel, either from IDLE or by preemption.
    if (start) begin
      state_d = ON;
      ch_d    = win_ch;
      hp_d    = win_hp;
      tone_d  = '0;
      cad_d   = '0;
      beep_d  = '0;
      buzz_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      hp_q    <= '0;
      tone_q  <= '0;
      cad_q   <= '0;
      beep_q  <= '0;
      buzz_q  <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
      cad_q   <= cad_d;
      beep_q  <= beep_d;
      buzz_q  <= buzz_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
    end
  end

  assign o_buzz    = buzz_q;
  assign active    = (state_q != IDLE);
  assign active_ch = ch_q;
  assign done      = done_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Self-checking bench for buzzer_tone_gen: directed vector table, hand-written
// cadence/reset sequences and randomized traffic against a phase-level model.
module tb_buzzer_tone_gen;
  import buzzer_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  req;
  logic [79:0] halfPer;
  logic [23:0] cadOn;
  logic [23:0] cadOff;
  logic [7:0]  maxBeeps;
  logic        ack;
  logic        oBuzz;
  logic        active;
  logic [1:0]  activeCh;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Reference model: which channel is sounding, which phase, time in phase.
  logic [3:0] mMask;
  bit         mActive;
  int         mCh;
  int         mHp;
  bit         mOff;
  int         mT;
  int         mBeeps;
  bit         mDone;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       expActive;
    logic [1:0] expCh;
    logic       expBuzz;
    logic       expDone;
  } vec_t;

  vec_t vecs[$];

  buzzer_tone_gen dut (
    .clk       (clk),
    .rst_n     (rstN),
    .req       (req),
    .half_per  (halfPer),
    .cad_on    (cadOn),
    .cad_off   (cadOff),
    .max_beeps (maxBeeps),
    .ack       (ack),
    .o_buzz    (oBuzz),
    .active    (active),
    .active_ch (activeCh),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setHp(input int ch, input int val);
    halfPer[ch*20 +: 20] = 20'(val);
  endtask

  task automatic modelReset();
    mMask = '0; mActive = 0; mCh = 0; mHp = 0; mOff = 0; mT = 0; mBeeps = 0; mDone = 0;
  endtask

  task automatic modelStart(input int w);
    mActive = 1; mCh = w; mHp = int'(halfPer[w*20 +: 20]);
    mOff = 0; mT = 0; mBeeps = 0;
  endtask

  // One clock of the alarm rules, evaluated on the inputs present before the edge.
  task automatic modelStep();
    logic [3:0] elig;
    logic [3:0] newMask;
    int  winner;
    int  effOn;
    elig    = req & ~mMask;
    newMask = mMask & req;
    winner  = -1;
    for (int i = 0; i < 4; i++) if (elig[i]) winner = i;
    mDone = 0;
    if (!mActive) begin
      if (winner >= 0) modelStart(winner);
    end else if (ack) begin
      newMask[mCh] = 1'b1;
      mActive = 0;
    end else if (!req[mCh]) begin
      mActive = 0;
    end else if (winner != mCh) begin
      modelStart(winner);
    end else if (!mOff) begin
      effOn = (cadOn == 0) ? 1 : int'(cadOn);
      if (cadOff != 0 && mT + 1 == effOn) begin
        mOff = 1; mT = 0;
        if (mBeeps < 255) mBeeps++;
      end else begin
        mT++;
      end
    end else begin
      if (cadOff == 0 || mT + 1 == int'(cadOff)) begin
        if (maxBeeps != 0 && mBeeps == int'(maxBeeps)) begin
          newMask[mCh] = 1'b1;
          mDone = 1;
          mActive = 0;
        end else begin
          mOff = 0; mT = 0; mHp = int'(halfPer[mCh*20 +: 20]);
        end
      end else begin
        mT++;
      end
    end
    mMask = newMask;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkAgainstModel();
    int expBuzz;
    expBuzz = (mActive && !mOff && mHp != 0 && ((mT / mHp) % 2 == 1)) ? 1 : 0;
    checkOutput("model_active", int'(active), int'(mActive));
    checkOutput("model_active_ch", int'(activeCh), mCh);
    checkOutput("model_o_buzz", int'(oBuzz), expBuzz);
    checkOutput("model_done", int'(done), int'(mDone));
  endtask

  initial begin
    int  expActive;
    int  expBuzz;
    int  expDone;
    int  t;
    bit  found;
    logic [3:0] rr;

    rstN = 1'b0; req = '0; ack = 1'b0; halfPer = '0;
    cadOn = '0; cadOff = '0; maxBeeps = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_o_buzz", int'(oBuzz), 0);
    checkOutput("reset_active", int'(active), 0);
    checkOutput("reset_active_ch", int'(activeCh), 0);
    checkOutput("reset_done", int'(done), 0);
    rstN = 1'b1;

    // Continuous tone on channel 0: half-period 4, first rise 4 cycles after entry.
    setHp(0, 4); setHp(1, 3); setHp(2, 2); setHp(3, 2);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput("cont_active", int'(active), 1);
      checkOutput("cont_buzz", int'(oBuzz), (k / 4) % 2);
    end
    applyStimulus(4'b0000, 1'b0);
    checkOutput("cont_stop", int'(active), 0);

    // Directed table: ack/preempt/drop corner cases with continuous tone.
    vecs.push_back('{4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{4'b1010, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b1010, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0});
    vecs.push_back('{4'b1010, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0});
    vecs.push_back('{4'b1010, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{4'b0101, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{4'b0101, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{4'b0101, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{4'b0101, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].ack);
      checkOutput($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].expActive));
      checkOutput($sformatf("vec%0d_active_ch", i), int'(activeCh), int'(vecs[i].expCh));
      checkOutput($sformatf("vec%0d_o_buzz", i), int'(oBuzz), int'(vecs[i].expBuzz));
      checkOutput($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].expDone));
    end

    // Three 16-cycle bursts with 8-cycle gaps, then auto-silence with done.
    setHp(0, 2); cadOn = 24'd16; cadOff = 24'd8; maxBeeps = 8'd3;
    for (int k = 0; k < 78; k++) begin
      applyStimulus(4'b0001, 1'b0);
      t = k % 24;
      expActive = (k < 72) ? 1 : 0;
      expBuzz   = (k < 72 && t < 16) ? (t / 2) % 2 : 0;
      expDone   = (k == 72) ? 1 : 0;
      checkOutput("beep_active", int'(active), expActive);
      checkOutput("beep_buzz", int'(oBuzz), expBuzz);
      checkOutput("beep_done", int'(done), expDone);
    end
    applyStimulus(4'b0000, 1'b0);
    checkOutput("rearm_idle", int'(active), 0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("rearm_restart", int'(active), 1);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);

    // Asynchronous reset while the buzzer output is high.
    setHp(0, 4); cadOff = '0; maxBeeps = '0;
    found = 0;
    for (int k = 0; k < 16 && !found; k++) begin
      applyStimulus(4'b0001, 1'b0);
      if (oBuzz) found = 1;
    end
    checkOutput("arst_buzz_high_seen", int'(found), 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_o_buzz", int'(oBuzz), 0);
    checkOutput("arst_active", int'(active), 0);
    checkOutput("arst_done", int'(done), 0);
    modelReset();
    #2;
    rstN = 1'b1;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("arst_restart_active", int'(active), 1);
    checkOutput("arst_restart_ch", int'(activeCh), 0);
    checkAgainstModel();

    // Randomized traffic; configuration changes only while idle.
    rr = 4'b0001;
    for (int seg = 0; seg < 25; seg++) begin
      applyStimulus(4'b0000, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      checkAgainstModel();
      for (int c = 0; c < 4; c++) setHp(c, int'($urandom_range(0, 5)));
      cadOn    = 24'($urandom_range(0, 6));
      cadOff   = 24'($urandom_range(0, 5));
      maxBeeps = 8'($urandom_range(0, 3));
      rr = 4'($urandom_range(0, 15));
      for (int c = 0; c < 50; c++) begin
        for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
        applyStimulus(rr, ($urandom_range(0, 15) == 0));
        checkAgainstModel();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
